// File: rtl/pmem_arbiter_if.sv
// Bundle of the icache, dcache and pmem line-port signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and pmem.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_resp;
  logic [LINE_WIDTH-1:0] i_rdata;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic                  d_resp;
  logic [LINE_WIDTH-1:0] d_rdata;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory line port between icache and dcache.
// Registers the granted request onto pmem and routes completion back to the owner.
module pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input logic              clk,
  input logic              rst,
  pmem_arbiter_if.slave    bus
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(32'h1f);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  i_resp_c, d_resp_c;
  logic                  d_req, pick_d;

  // State and pmem request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Arbitration, grant capture and completion routing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_resp_c     = 1'b0;
    d_resp_c     = 1'b0;
    d_req        = bus.d_read | bus.d_write;
    // On contention the side that did not win last time is served
    pick_d       = d_req & (~bus.i_read | ~last_grant_q);

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d      = GNT_D;
          last_grant_d = 1'b1;
          addr_d       = bus.d_addr & LINE_MASK;
          wdata_d      = bus.d_wdata;
          write_d      = bus.d_write;
          read_d       = bus.d_read & ~bus.d_write;
        end else if (bus.i_read) begin
          state_d      = GNT_I;
          last_grant_d = 1'b0;
          addr_d       = bus.i_addr & LINE_MASK;
          write_d      = 1'b0;
          read_d       = 1'b1;
        end
      end
      GNT_I: begin
        if (bus.pmem_resp) begin
          i_resp_c = 1'b1;
          read_d   = 1'b0;
          write_d  = 1'b0;
          state_d  = DONE;
        end
      end
      GNT_D: begin
        if (bus.pmem_resp) begin
          d_resp_c = 1'b1;
          read_d   = 1'b0;
          write_d  = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_resp       = i_resp_c;
  assign bus.d_resp       = d_resp_c;
  assign bus.i_rdata      = bus.pmem_rdata;
  assign bus.d_rdata      = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: expected pmem transactions and responses are
// queued as requests are driven, then popped as the arbiter issues them.
module tb_pmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic clk;
  logic rst;

  pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

  pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  function automatic exp_t mk(input logic is_d, input logic [AW-1:0] addr, input logic rd,
                              input logic wr, input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.rd = rd; e.wr = wr; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // Wait for the next pmem strobe, check it against the queue head, hold it for
  // lat cycles and complete it, checking the routed response.
  task automatic serve(input int lat);
    exp_t e;
    bit   seen;
    e    = sb.pop_front();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.pmem_read | bus.pmem_write;
    end
    check("strobe_seen", LW'(seen), LW'(1));
    check("pmem_address", LW'(bus.pmem_address), LW'(e.addr));
    check("pmem_read", LW'(bus.pmem_read), LW'(e.rd));
    check("pmem_write", LW'(bus.pmem_write), LW'(e.wr));
    if (e.wr) check("pmem_wdata", bus.pmem_wdata, e.wdata);
    for (int k = 2; k <= lat; k++) begin
      @(negedge clk);
      check("strobe_held", LW'({bus.pmem_read, bus.pmem_write}), LW'({e.rd, e.wr}));
      check("no_early_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    end
    bus.pmem_rdata = e.rdata;
    bus.pmem_resp  = 1'b1;
    #1;
    check(e.is_d ? "d_resp" : "i_resp", LW'({bus.i_resp, bus.d_resp}), LW'({~e.is_d, e.is_d}));
    check("rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
    check("strobes_cleared", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    check("resp_after", LW'({bus.i_resp, bus.d_resp}), LW'(0));
  endtask

  logic [LW-1:0] a5;
  bit            seen5;

  initial begin
    a5 = {32{8'hA5}};
    rst = 1'b1;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    #1;
    check("rst_strobes", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    check("rst_address", LW'(bus.pmem_address), LW'(0));
    check("rst_wdata", bus.pmem_wdata, LW'(0));
    check("rst_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: icache read, address offset masked, 5-cycle pmem latency
    @(posedge clk); #1;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_0064;
    sb.push_back(mk(1'b0, 32'h0000_0060, 1'b1, 1'b0, '0, {8{32'h1111_2222}}));
    serve(5);
    bus.i_read = 1'b0;

    // 2: dcache writeback
    @(posedge clk); #1;
    bus.d_write = 1'b1; bus.d_addr = 32'h8000_0020; bus.d_wdata = a5;
    sb.push_back(mk(1'b1, 32'h8000_0020, 1'b0, 1'b1, a5, {8{32'h3333_4444}}));
    serve(3);
    bus.d_write = 1'b0;

    // 3: both requesting straight out of reset; D first since last_grant resets to I
    @(negedge clk);
    rst = 1'b1;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_1004;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_2008;
    sb.push_back(mk(1'b1, 32'h0000_2000, 1'b1, 1'b0, '0, {8{32'h5555_0001}}));
    sb.push_back(mk(1'b0, 32'h0000_1000, 1'b1, 1'b0, '0, {8{32'h5555_0002}}));
    @(negedge clk);
    rst = 1'b0;
    serve(2);
    bus.d_read = 1'b0;
    serve(2);
    bus.i_read = 1'b0;

    // 4: both held for four transfers; grants must alternate D, I, D, I
    @(posedge clk); #1;
    bus.i_read = 1'b1; bus.i_addr = 32'h0000_3000;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_4000;
    for (int t = 0; t < 4; t++) begin
      logic is_d;
      is_d = (t % 2 == 0);
      sb.push_back(mk(is_d, is_d ? 32'h0000_4000 : 32'h0000_3000, 1'b1, 1'b0, '0,
                      {8{32'hCAFE_0000 + 32'(t)}}));
    end
    for (int t = 0; t < 4; t++) serve(1 + t);
    bus.i_read = 1'b0; bus.d_read = 1'b0;

    // 5: reset while a dcache read is in flight drops the strobe and its response
    @(posedge clk); #1;
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_0100;
    seen5 = 1'b0;
    for (int c = 0; c < 20 && !seen5; c++) begin
      @(negedge clk);
      seen5 = bus.pmem_read;
    end
    check("t5_strobe_seen", LW'(seen5), LW'(1));
    rst = 1'b1;
    bus.d_read = 1'b0;
    #1;
    check("t5_async_drop", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    @(negedge clk);
    rst = 1'b0;
    bus.pmem_resp = 1'b1; bus.pmem_rdata = {8{32'hDEAD_BEEF}};
    #1;
    check("t5_no_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("t5_idle_strobes", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));

    // 6: stray pmem_resp in IDLE, then read+write together treated as a write
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    #1;
    check("t6_stray_resp", LW'({bus.i_resp, bus.d_resp}), LW'(0));
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("t6_stray_strobes", LW'({bus.pmem_read, bus.pmem_write}), LW'(0));
    @(posedge clk); #1;
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 32'h0000_0040;
    bus.d_wdata = {8{32'h0F0F_0F0F}};
    sb.push_back(mk(1'b1, 32'h0000_0040, 1'b0, 1'b1, {8{32'h0F0F_0F0F}}, {8{32'h7777_8888}}));
    serve(1);
    bus.d_read = 1'b0; bus.d_write = 1'b0;

    repeat (3) @(negedge clk);
    check("sb_drained", LW'(sb.size()), LW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
